// File: rtl/sad_search_ctrl_pkg.sv
// Shared definitions for the SAD motion-search controller: FSM encoding,
// datapath widths and the absolute-difference helper.
package sad_search_ctrl_pkg;

  localparam int PIX_W      = 8;
  localparam int QUAD_SAD_W = 10;  // 4 * 255 = 1020 fits in 10 bits
  localparam int ACC_W      = 12;  // 4 * 1020 = 4080 fits in 12 bits
  localparam int NQUAD      = 4;   // 2x2 quads per 4x4 block

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // |x - y| for two unsigned pixels, never wraps
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] x,
                                                 input logic [PIX_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/sad_search_ctrl_sum_difabs.sv
// Combinational 2x2 sum of absolute differences between a current-block
// quad and a candidate quad. Result range 0..1020.
module sum_difabs
  import sad_search_ctrl_pkg::*;
(
  input  logic [PIX_W-1:0]      a00_i,
  input  logic [PIX_W-1:0]      a01_i,
  input  logic [PIX_W-1:0]      a10_i,
  input  logic [PIX_W-1:0]      a11_i,
  input  logic [PIX_W-1:0]      b00_i,
  input  logic [PIX_W-1:0]      b01_i,
  input  logic [PIX_W-1:0]      b10_i,
  input  logic [PIX_W-1:0]      b11_i,
  output logic [QUAD_SAD_W-1:0] sad_o
);

  // Each difference is widened before the add so the sum cannot wrap
  always_comb begin
    sad_o = QUAD_SAD_W'(abs_diff(a00_i, b00_i))
          + QUAD_SAD_W'(abs_diff(a01_i, b01_i))
          + QUAD_SAD_W'(abs_diff(a10_i, b10_i))
          + QUAD_SAD_W'(abs_diff(a11_i, b11_i));
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// SAD search controller: accumulates four 2x2 quad SADs per candidate
// into a 4x4 block SAD, keeps the strict minimum over NCAND candidates
// and pulses done at the end of the search.
//
// Handshake: a quad is consumed on a rising edge where in_valid && in_ready
// and abort is low. in_ready is high exactly in RUN; abort takes priority,
// so a quad presented in the abort cycle is discarded.
module sad_search_ctrl
  import sad_search_ctrl_pkg::*;
#(
  parameter int NCAND = 16,
  parameter int IDXW  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [7:0]      a00,
  input  logic [7:0]      a01,
  input  logic [7:0]      a10,
  input  logic [7:0]      a11,
  input  logic [7:0]      b00,
  input  logic [7:0]      b01,
  input  logic [7:0]      b10,
  input  logic [7:0]      b11,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [1:0]      quad_idx,
  output logic [IDXW-1:0] cand_idx,
  output logic            busy,
  output logic            done,
  output logic [11:0]     best_sad,
  output logic [IDXW-1:0] best_idx,
  output logic [1:0]      dbg_state
);

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [1:0]              quad_q, quad_d;
  logic [IDXW-1:0]         cand_q, cand_d;
  logic [ACC_W-1:0]        best_sad_q, best_sad_d;
  logic [IDXW-1:0]         best_idx_q, best_idx_d;

  logic [QUAD_SAD_W-1:0]   quad_sad;
  logic                    accept;
  logic                    last_quad;
  logic                    last_cand;

  sum_difabs u_sum_difabs (
    .a00_i (a00),
    .a01_i (a01),
    .a10_i (a10),
    .a11_i (a11),
    .b00_i (b00),
    .b01_i (b01),
    .b10_i (b10),
    .b11_i (b11),
    .sad_o (quad_sad)
  );

  assign accept    = (state_q == ST_RUN) && in_valid && !abort;
  assign last_quad = (quad_q == 2'(NQUAD - 1));
  assign last_cand = (cand_q == IDXW'(NCAND - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; abort wins over acceptance and compare
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (abort)                      state_d = ST_IDLE;
        else if (in_valid && last_quad) state_d = ST_CMP;
      end
      ST_CMP: begin
        if (abort)          state_d = ST_IDLE;
        else if (last_cand) state_d = ST_DONE;
        else                state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state only
  always_comb begin
    in_ready  = (state_q == ST_RUN);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // Datapath next values: accumulator, quad/candidate counters, best match
  always_comb begin
    acc_d      = acc_q;
    quad_d     = quad_q;
    cand_d     = cand_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d      = '0;
          quad_d     = '0;
          cand_d     = '0;
          best_sad_d = '1;
          best_idx_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          acc_d  = acc_q + ACC_W'(quad_sad);
          quad_d = quad_q + 2'd1;
        end
      end
      ST_CMP: begin
        if (!abort) begin
          // Strict compare: on a tie the earlier candidate is kept
          if (acc_q < best_sad_q) begin
            best_sad_d = acc_q;
            best_idx_d = cand_q;
          end
          if (!last_cand) begin
            cand_d = cand_q + IDXW'(1);
            acc_d  = '0;
            quad_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      quad_q     <= '0;
      cand_q     <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
    end else begin
      acc_q      <= acc_d;
      quad_q     <= quad_d;
      cand_q     <= cand_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign quad_idx = quad_q;
  assign cand_idx = cand_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl with NCAND=4: randomized and directed searches,
// expected results queued at start and checked when done pulses.
module tb_sad_search_ctrl;

  localparam int NCAND = 4;
  localparam int IDXW  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            start, abort, in_valid;
  logic [7:0]      a00, a01, a10, a11, b00, b01, b10, b11;
  logic            in_ready, busy, done;
  logic [1:0]      quad_idx, dbg_state;
  logic [IDXW-1:0] cand_idx, best_idx;
  logic [11:0]     best_sad;

  sad_search_ctrl #(.NCAND(NCAND), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .in_valid(in_valid), .in_ready(in_ready),
    .quad_idx(quad_idx), .cand_idx(cand_idx),
    .busy(busy), .done(done),
    .best_sad(best_sad), .best_idx(best_idx),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  // {expected done cycle[31:0], best_sad[11:0], best_idx[3:0]}
  logic [47:0] exp_q[$];
  logic [47:0] exp_e;

  int pa[4][4][4];   // [cand][quad][pixel]
  int pb[4][4][4];
  int gaps[4][4];    // idle RUN cycles before each quad

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic gen_data(input int mode);
    int d[4];
    d = '{4, 1, 2, 1};
    for (int c = 0; c < 4; c++)
      for (int q = 0; q < 4; q++)
        for (int p = 0; p < 4; p++) begin
          case (mode)
            0: begin pa[c][q][p] = $urandom_range(0, 255); pb[c][q][p] = $urandom_range(0, 255); end
            1: begin pa[c][q][p] = 77;  pb[c][q][p] = 77; end
            2: begin pa[c][q][p] = 100; pb[c][q][p] = 100 + d[c]; end
            3: begin pa[c][q][p] = 255; pb[c][q][p] = 0; end
            default: begin pa[c][q][p] = $urandom_range(0, 3); pb[c][q][p] = $urandom_range(0, 3); end
          endcase
        end
  endtask

  task automatic gen_gaps(input int gmode, output int gsum);
    gsum = 0;
    for (int c = 0; c < 4; c++)
      for (int q = 0; q < 4; q++) begin
        case (gmode)
          0:       gaps[c][q] = 0;
          1:       gaps[c][q] = 1;
          default: gaps[c][q] = $urandom_range(0, 3);
        endcase
        gsum += gaps[c][q];
      end
  endtask

  // Best block SAD over the first ncand candidates; first minimum wins.
  // The initial best value is the all-ones value loaded at start.
  task automatic ref_best(input int ncand, output int bsad, output int bidx);
    int s, x, y;
    bsad = 4095;
    bidx = 0;
    for (int c = 0; c < ncand; c++) begin
      s = 0;
      for (int q = 0; q < 4; q++)
        for (int p = 0; p < 4; p++) begin
          x = pa[c][q][p];
          y = pb[c][q][p];
          s += (x > y) ? (x - y) : (y - x);
        end
      if (s < bsad) begin
        bsad = s;
        bidx = c;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drivers run at #1 after a rising edge.
  task automatic do_start(input logic with_abort);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("best_sad_init", 32'(best_sad), 32'd4095);
    check("best_idx_init", 32'(best_idx), 32'd0);
  endtask

  task automatic drive_quad(input int c, input int q, input logic glitch_start);
    repeat (gaps[c][q]) begin
      @(posedge clk); #1;
    end
    check("in_ready_run", 32'(in_ready), 32'd1);
    check("quad_idx", 32'(quad_idx), 32'(q));
    check("cand_idx", 32'(cand_idx), 32'(c));
    a00 = 8'(pa[c][q][0]); a01 = 8'(pa[c][q][1]); a10 = 8'(pa[c][q][2]); a11 = 8'(pa[c][q][3]);
    b00 = 8'(pb[c][q][0]); b01 = 8'(pb[c][q][1]); b10 = 8'(pb[c][q][2]); b11 = 8'(pb[c][q][3]);
    in_valid = 1'b1;
    start    = glitch_start;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_search(input int mode, input int gmode, input int glitch_cand,
                            input logic abort_with_start);
    int gsum, bsad, bidx, c0;
    gen_data(mode);
    gen_gaps(gmode, gsum);
    ref_best(NCAND, bsad, bidx);
    do_start(abort_with_start);
    c0 = cyc;
    exp_q.push_back({32'(c0 + 5 * NCAND + gsum), 12'(bsad), 4'(bidx)});
    for (int c = 0; c < NCAND; c++) begin
      for (int q = 0; q < 4; q++) drive_quad(c, q, (c == glitch_cand) && (q == 2));
      check("in_ready_cmp", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    // now in the done cycle; one more edge returns to idle
    @(posedge clk); #1;
    check("busy_idle", 32'(busy), 32'd0);
    check("best_sad_hold", 32'(best_sad), 32'(bsad));
    check("best_idx_hold", 32'(best_idx), 32'(bidx));
  endtask

  task automatic abort_test();
    int gsum, bsad, bidx;
    gen_data(0);
    gen_gaps(0, gsum);
    ref_best(2, bsad, bidx);
    do_start(1'b0);
    for (int c = 0; c < 2; c++) begin
      for (int q = 0; q < 4; q++) drive_quad(c, q, 1'b0);
      @(posedge clk); #1;
    end
    drive_quad(2, 0, 1'b0);
    check("abort_quad_idx", 32'(quad_idx), 32'd1);
    check("abort_cand_idx", 32'(cand_idx), 32'd2);
    in_valid = 1'b1;
    abort    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort    = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_best_sad", 32'(best_sad), 32'(bsad));
    check("abort_best_idx", 32'(best_idx), 32'(bidx));
    @(posedge clk); #1;
    check("abort_stay_idle", 32'(busy), 32'd0);
  endtask

  task automatic reset_test();
    int gsum;
    gen_data(0);
    gen_gaps(0, gsum);
    do_start(1'b0);
    for (int q = 0; q < 4; q++) drive_quad(0, q, 1'b0);
    @(posedge clk); #1;
    drive_quad(1, 0, 1'b0);
    drive_quad(1, 1, 1'b0);
    #2;
    rst = 1'b1;   // away from any clock edge
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_best_sad", 32'(best_sad), 32'd0);
    check("rst_best_idx", 32'(best_idx), 32'd0);
    check("rst_quad_idx", 32'(quad_idx), 32'd0);
    check("rst_cand_idx", 32'(cand_idx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_released_idle", 32'(busy), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
      end else begin
        exp_e = exp_q.pop_front();
        check("done_cycle", 32'(cyc), exp_e[47:16]);
        check("best_sad", 32'(best_sad), 32'(exp_e[15:4]));
        check("best_idx", 32'(best_idx), 32'(exp_e[3:0]));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    a00 = '0; a01 = '0; a10 = '0; a11 = '0;
    b00 = '0; b01 = '0; b10 = '0; b11 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_best_sad", 32'(best_sad), 32'd0);
    check("reset_best_idx", 32'(best_idx), 32'd0);
    check("reset_quad_idx", 32'(quad_idx), 32'd0);
    check("reset_cand_idx", 32'(cand_idx), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_search(1, 0, -1, 1'b0);  // all equal: 0 at candidate 0
    run_search(2, 0, -1, 1'b0);  // 64,16,32,16 -> 16 at candidate 1
    run_search(3, 0, -1, 1'b0);  // 4080, no wrap
    run_search(0, 0, -1, 1'b0);  // random, continuous valid
    run_search(0, 1, -1, 1'b0);  // valid every other cycle
    run_search(0, 2, 2, 1'b0);   // random gaps, start pulsed mid-run
    run_search(4, 2, -1, 1'b1);  // many ties, abort together with start in idle
    abort_test();
    reset_test();
    run_search(0, 2, -1, 1'b0);  // full search after reset
    for (int i = 0; i < 6; i++)
      run_search($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 4), 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_search_ctrl.md
SAD_SEARCH_CTRL -- requirements
Module: sad_search_ctrl

Interface
REQ-001 SHALL have parameter NCAND, default 16, meaning number of candidate positions per search (1..16).
REQ-002 SHALL have parameter IDXW, default 4, meaning width of candidate index; NCAND <= 2**IDXW.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a search; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous cancel of a running search.
REQ-007 SHALL have ports a00,a01,a10,a11  input  8 each  current-block 2x2 pixel quad, unsigned.
REQ-008 SHALL have ports b00,b01,b10,b11  input  8 each  candidate 2x2 pixel quad, unsigned.
REQ-009 SHALL have port in_valid  input  1  pixel quad present.
REQ-010 SHALL have port in_ready  output  1  controller accepts quad this cycle.
REQ-011 SHALL have port quad_idx  output  2  index (0..3) of the quad expected next, for address generation.
REQ-012 SHALL have port cand_idx  output  IDXW  candidate currently being evaluated.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse: search complete.
REQ-015 SHALL have port best_sad  output  12  minimum 4x4 block SAD found.
REQ-016 SHALL have port best_idx  output  IDXW  candidate index of best_sad.

Function
REQ-017 SHALL evaluate one 4x4 block per candidate as four 2x2 quads; quad SAD = sum of four |a-b|, 10 bits, max 1020.
REQ-018 SHALL accumulate the four quad SADs into a 12-bit accumulator (max 4080); no saturation or truncation is permitted.
REQ-019 SHALL implement FSM states IDLE, RUN, CMP, DONE.
REQ-020 IDLE: in_ready=0; start=1 -> RUN, clear accumulator, quad_idx=0, cand_idx=0, best_sad=12'hFFF, best_idx=0.
REQ-021 RUN: in_ready=1; a quad is accepted when in_valid && in_ready; each acceptance adds the quad SAD and increments quad_idx; acceptance at quad_idx=3 -> CMP.
REQ-022 RUN with in_valid=0 SHALL hold all state; gaps of any length are legal.
REQ-023 CMP (exactly one cycle, in_ready=0): if accumulator < best_sad (strict), load best_sad/best_idx; ties keep the earlier candidate.
REQ-024 CMP: if cand_idx==NCAND-1 -> DONE; else cand_idx+1, accumulator=0, quad_idx=0 -> RUN.
REQ-025 DONE: done=1 for one cycle -> IDLE; best_sad/best_idx hold until the next accepted start.
REQ-026 Latency with in_valid held high: 5*NCAND cycles from start acceptance to DONE entry; done high in cycle 5*NCAND+1.
REQ-027 start outside IDLE SHALL be ignored.
REQ-028 abort in RUN or CMP SHALL force IDLE next cycle with no done pulse; best_* keep current values; abort has priority over acceptance and compare.
REQ-029 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-030 rst SHALL asynchronously force IDLE, accumulator=0, quad_idx=0, cand_idx=0, best_sad=0, best_idx=0, done=0, busy=0, in_ready=0, including mid-search.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, QUAD_SAD_W=10, ACC_W=12, NQUAD=4.
REQ-032 SHALL instantiate exactly one combinational sub-module, sum_difabs (2x2 SAD, 10-bit output), fed directly by a00..b11.

Verification
REQ-033 NCAND=4, all a=b=77 -> best_sad=0, best_idx=0 (tie rule).
REQ-034 NCAND=4, a=100, b=100+d with d=4,1,2,1 per candidate -> block SADs 64,16,32,16; best_sad=16, best_idx=1.
REQ-035 NCAND=1, a=255, b=0 -> best_sad=4080, no wrap.
REQ-036 NCAND=4, in_valid high continuously -> done high exactly in cycle 21 after start sampled; in_valid toggling every other cycle -> same result, done delayed by the number of idle RUN cycles.
REQ-037 start pulsed during RUN -> ignored; abort at cand_idx=2, quad_idx=1 -> IDLE next cycle, no done, best_* retained.
REQ-038 rst asserted mid-RUN -> all outputs per REQ-030 immediately, without waiting for a clock edge; a new start after release -> full correct search.
